// File: rtl/accum_nd.sv
// accum_nd: multi-channel accumulator with a four-phase en/done handshake.
// One operation (ADD, SUB, LOAD, CLEAR) is applied per handshake to the channel
// selected by ch. Each channel keeps a sticky overflow/underflow flag.
// Optional feature: define ACCUM_SAT_EN to saturate results instead of wrapping.
module accum_nd #(
    parameter int unsigned ACCUM_WIDTH = 64,
    parameter int unsigned ADD_WIDTH   = 32,
    parameter int unsigned CHANNELS    = 4,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_l,
    input  logic                            en,
    input  logic [1:0]                      op,
    input  logic [CH_W-1:0]                 ch,
    input  logic [ADD_WIDTH-1:0]            operand,
    output logic [CHANNELS*ACCUM_WIDTH-1:0] accum,
    output logic [CHANNELS-1:0]             ovf,
    output logic                            done,
    output logic                            err
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_t;

    typedef enum logic [1:0] {
        OpAdd   = 2'b00,
        OpSub   = 2'b01,
        OpLoad  = 2'b10,
        OpClear = 2'b11
    } op_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_op;
    logic [CH_W-1:0]        r_ch;
    logic [ADD_WIDTH-1:0]   r_operand;
    logic [ACCUM_WIDTH-1:0] r_acc [CHANNELS];
    logic [ACCUM_WIDTH-1:0] w_acc_nxt [CHANNELS];
    logic [CHANNELS-1:0]    r_ovf;
    logic [CHANNELS-1:0]    w_ovf_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   r_err;
    logic                   w_err_nxt;

    logic                   w_bad_ch;
    logic [ACCUM_WIDTH-1:0] w_sel_acc;
    logic                   w_sel_ovf;
    logic [ACCUM_WIDTH-1:0] w_ext;
    logic [ACCUM_WIDTH:0]   w_sum;
    logic [ACCUM_WIDTH:0]   w_diff;
    logic [ACCUM_WIDTH-1:0] w_res;
    logic                   w_res_ovf;

    assign w_bad_ch = (32'(r_ch) >= CHANNELS);
    assign w_ext    = ACCUM_WIDTH'(r_operand);
    // One extra bit catches the carry of ADD and the borrow of SUB.
    assign w_sum    = {1'b0, w_sel_acc} + {1'b0, w_ext};
    assign w_diff   = {1'b0, w_sel_acc} - {1'b0, w_ext};

    // Select the addressed channel's accumulator and flag; zero when out of range.
    always_comb begin
        w_sel_acc = '0;
        w_sel_ovf = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(r_ch) == k) begin
                w_sel_acc = r_acc[k];
                w_sel_ovf = r_ovf[k];
            end
        end
    end

    // Compute the result and new sticky flag for the captured operation.
    always_comb begin
        w_res     = w_sel_acc;
        w_res_ovf = w_sel_ovf;
        unique case (op_t'(r_op))
            OpAdd: begin
`ifdef ACCUM_SAT_EN
                w_res = w_sum[ACCUM_WIDTH] ? '1 : w_sum[ACCUM_WIDTH-1:0];
`else
                w_res = w_sum[ACCUM_WIDTH-1:0];
`endif
                w_res_ovf = w_sel_ovf | w_sum[ACCUM_WIDTH];
            end
            OpSub: begin
`ifdef ACCUM_SAT_EN
                w_res = w_diff[ACCUM_WIDTH] ? '0 : w_diff[ACCUM_WIDTH-1:0];
`else
                w_res = w_diff[ACCUM_WIDTH-1:0];
`endif
                w_res_ovf = w_sel_ovf | w_diff[ACCUM_WIDTH];
            end
            OpLoad: begin
                w_res     = w_ext;
                w_res_ovf = 1'b0;
            end
            OpClear: begin
                w_res     = '0;
                w_res_ovf = 1'b0;
            end
        endcase
    end

    // Next-state logic for the handshake FSM and the accumulator bank.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        unique case (r_state)
            StIdle: begin
                if (en) begin
                    w_state_nxt = StExec;
                end
            end
            StExec: begin
                w_done_nxt  = 1'b1;
                w_err_nxt   = w_bad_ch;
                w_state_nxt = StDone;
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    if (!w_bad_ch && (32'(r_ch) == k)) begin
                        w_acc_nxt[k] = w_res;
                        w_ovf_nxt[k] = w_res_ovf;
                    end
                end
            end
            StDone: begin
                if (!en) begin
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, accumulator and status registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= StIdle;
            r_acc   <= '{default: '0};
            r_ovf   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Capture the request in IDLE so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_op      <= '0;
            r_ch      <= '0;
            r_operand <= '0;
        end else if ((r_state == StIdle) && en) begin
            r_op      <= op;
            r_ch      <= ch;
            r_operand <= operand;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_flat
        assign accum[k*ACCUM_WIDTH +: ACCUM_WIDTH] = r_acc[k];
    end

    assign ovf  = r_ovf;
    assign done = r_done;
    assign err  = r_err;

endmodule
